// File: rtl/dbus_ctrl.sv
// Data-bus controller bridging the MM-stage load/store port to a split
// address/data handshake bus, one outstanding transaction at a time.
module dbus_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dbus_en,
    input  logic [3:0]  dbus_we,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_data,
    input  logic        except,
    input  logic        flush,
    output logic        stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata,
    output logic        rdata_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        discard_q, discard_nxt;

    logic        accept;
    logic        discarding;
    logic        complete;
    logic        capture;
    logic [1:0]  size_dec;

    always_comb begin
        case (dbus_we)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size_dec = 2'd0;
            4'b0011, 4'b1100:                   size_dec = 2'd1;
            default:                            size_dec = 2'd2;
        endcase
    end

    // A flush landing in the completion cycle itself also discards the result.
    always_comb begin
        accept      = (state == IDLE) & dbus_en & ~except & ~flush;
        discarding  = discard_q | flush;
        complete    = ((state == REQ) & data_addr_ok & data_data_ok) |
                      ((state == WAIT) & data_data_ok);
        capture     = complete & ~discarding & ~wr_q;
        state_nxt   = state;
        discard_nxt = discard_q;
        case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                if (flush) discard_nxt = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) state_nxt = discarding ? IDLE : DONE;
                    else              state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) discard_nxt = 1'b1;
                if (data_data_ok) state_nxt = discarding ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (complete) discard_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            discard_q <= discard_nxt;
            if (accept) begin
                wr_q    <= |dbus_we;
                size_q  <= size_dec;
                addr_q  <= (|dbus_we) ? dbus_addr : {dbus_addr[31:2], 2'b00};
                wdata_q <= dbus_data;
            end
            if (capture) rdata_q <= data_rdata;
        end
    end

    assign data_req    = (state == REQ);
    assign data_wr     = wr_q;
    assign data_size   = size_q;
    assign data_addr   = addr_q;
    assign data_wdata  = wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = (state == DONE) & ~wr_q & ~flush;
    assign stall       = accept | (state == REQ) | (state == WAIT);

endmodule
